// File: rtl/index_table_writer_pkg.sv
// Shared types and constants for the index-table writer: entry layout, FSM states
// and the lookup read latency.
package index_table_pkg;

  localparam int ADDR_WIDTH_MASKS = 11;
  localparam int ADDR_WIDTH_ACT   = 14;
  localparam int TABLE_DEPTH      = 2 ** (ADDR_WIDTH_MASKS - 1);
  localparam int TABLE_AW         = ADDR_WIDTH_MASKS - 1;
  localparam int ITW_READ_LATENCY = 2;

  typedef struct packed {
    logic [ADDR_WIDTH_ACT-1:0] start_row;
    logic [ADDR_WIDTH_ACT-1:0] num_rows;
  } index_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } itw_state_t;

  // True when a 32-bit difference does not fit in a stored row field.
  function automatic logic exceeds_act(input logic [31:0] diff);
    return |diff[31:ADDR_WIDTH_ACT];
  endfunction

endpackage

// File: rtl/index_table_writer_if.sv
// Lookup port between the compressed-activation fetch controller (master) and the
// index-table writer (slave).
interface index_table_writer_if;
  import index_table_pkg::*;

  // Request: a lookup transfers on any cycle where lookup_valid && lookup_ready;
  // the master holds lookup_index stable while lookup_valid is high and not yet
  // accepted. Response: result_valid is a one-cycle strobe with no back-pressure,
  // and the result fields keep their value until the next strobe.
  logic                        lookup_valid;
  logic                        lookup_ready;
  logic [ADDR_WIDTH_MASKS-2:0] lookup_index;
  logic                        result_valid;
  logic [ADDR_WIDTH_ACT-1:0]   result_start_row;
  logic [ADDR_WIDTH_ACT-1:0]   result_num_rows;
  logic                        result_err;

  modport master (
    output lookup_valid,
    output lookup_index,
    input  lookup_ready,
    input  result_valid,
    input  result_start_row,
    input  result_num_rows,
    input  result_err
  );

  modport slave (
    input  lookup_valid,
    input  lookup_index,
    output lookup_ready,
    output result_valid,
    output result_start_row,
    output result_num_rows,
    output result_err
  );

endinterface

// File: rtl/index_table_writer_mem.sv
// Entry storage for the index table: one write port, one synchronously read port,
// no reset on the array or the read register.
module index_table_mem
  import index_table_pkg::*;
#(
  parameter int DEPTH = TABLE_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  index_entry_t wr_data,
  input  logic         rd_en,
  input  logic [AW-1:0] rd_addr,
  output index_entry_t rd_data
);

  index_entry_t mem_q [DEPTH];
  index_entry_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/index_table_writer.sv
// Turns cumulative activation-row totals into per-group {start_row, num_rows}
// entries, stores them, and serves fixed-latency lookups once the layer is filled.
module index_table_writer
  import index_table_pkg::*;
(
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        start,
  input  logic [ADDR_WIDTH_MASKS-1:0] expected_entries,
  input  logic                        delayed_CE,
  input  logic [ADDR_WIDTH_MASKS-1:0] delayed_masks_transferred,
  input  logic [31:0]                 activation_rows_total,
  output logic                        fill_done,
  output logic                        overflow,
  output itw_state_t                  dbg_state,
  index_table_writer_if.slave         lk
);

  localparam logic [ADDR_WIDTH_MASKS-1:0] CNT_ONE = ADDR_WIDTH_MASKS'(1);

  itw_state_t                  state_q, state_d;
  logic [31:0]                 prev_total_q, prev_total_d;
  logic [31:0]                 base_q, base_d;
  logic [ADDR_WIDTH_MASKS-1:0] entry_cnt_q, entry_cnt_d;
  logic [ADDR_WIDTH_MASKS-1:0] expected_q, expected_d;
  logic                        overflow_q, overflow_d;
  logic [ITW_READ_LATENCY-1:0] lat_q, lat_d;
  logic                        err_pipe_q, err_pipe_d;
  logic [ADDR_WIDTH_ACT-1:0]   res_start_q, res_start_d;
  logic [ADDR_WIDTH_ACT-1:0]   res_num_q, res_num_d;
  logic                        res_err_q, res_err_d;

  logic                        odd_strobe;
  logic                        wr_accept;
  logic                        lookup_fire;
  logic [31:0]                 diff_start;
  logic [31:0]                 diff_num;
  logic [ADDR_WIDTH_MASKS-1:0] cnt_inc;
  index_entry_t                wr_entry;
  index_entry_t                rd_entry;

  // Even indices are the first half of a mask pair and carry no complete total.
  assign odd_strobe  = delayed_CE && delayed_masks_transferred[0];
  assign wr_accept   = (state_q == FILL) && odd_strobe;
  assign diff_start  = prev_total_q - base_q;
  assign diff_num    = activation_rows_total - prev_total_q;
  assign cnt_inc     = entry_cnt_q + CNT_ONE;
  assign lookup_fire = lk.lookup_valid && lk.lookup_ready;

  assign wr_entry.start_row = diff_start[ADDR_WIDTH_ACT-1:0];
  assign wr_entry.num_rows  = diff_num[ADDR_WIDTH_ACT-1:0];

  index_table_mem #(
    .DEPTH (TABLE_DEPTH),
    .AW    (TABLE_AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept && !start),
    .wr_addr (delayed_masks_transferred[ADDR_WIDTH_MASKS-1:1]),
    .wr_data (wr_entry),
    .rd_en   (lookup_fire),
    .rd_addr (lk.lookup_index),
    .rd_data (rd_entry)
  );

  always_comb begin
    state_d      = state_q;
    prev_total_d = prev_total_q;
    base_d       = base_q;
    entry_cnt_d  = entry_cnt_q;
    expected_d   = expected_q;
    overflow_d   = overflow_q;
    lat_d        = {lat_q[ITW_READ_LATENCY-2:0], lookup_fire};
    err_pipe_d   = err_pipe_q;
    res_start_d  = res_start_q;
    res_num_d    = res_num_q;
    res_err_d    = res_err_q;

    // Tracks the upstream accumulator in every state so the next layer's base is right.
    if (odd_strobe) begin
      prev_total_d = activation_rows_total;
    end

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      FILL: begin
        if (wr_accept) begin
          entry_cnt_d = cnt_inc;
          if (exceeds_act(diff_start) || exceeds_act(diff_num)) begin
            overflow_d = 1'b1;
          end
        end
        if ((entry_cnt_q == expected_q) || (wr_accept && (cnt_inc == expected_q))) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (lookup_fire) begin
      err_pipe_d = ({1'b0, lk.lookup_index} >= expected_q);
    end

    if (lat_q[0] && !start) begin
      res_err_d   = err_pipe_q;
      res_start_d = err_pipe_q ? '0 : rd_entry.start_row;
      res_num_d   = err_pipe_q ? '0 : rd_entry.num_rows;
    end

    // start overrides a same-cycle write and discards any lookup in flight.
    if (start) begin
      state_d     = FILL;
      entry_cnt_d = '0;
      expected_d  = expected_entries;
      base_d      = prev_total_q;
      overflow_d  = 1'b0;
      lat_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q      <= IDLE;
      prev_total_q <= '0;
      base_q       <= '0;
      entry_cnt_q  <= '0;
      expected_q   <= '0;
      overflow_q   <= 1'b0;
      lat_q        <= '0;
      err_pipe_q   <= 1'b0;
      res_start_q  <= '0;
      res_num_q    <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_total_q <= prev_total_d;
      base_q       <= base_d;
      entry_cnt_q  <= entry_cnt_d;
      expected_q   <= expected_d;
      overflow_q   <= overflow_d;
      lat_q        <= lat_d;
      err_pipe_q   <= err_pipe_d;
      res_start_q  <= res_start_d;
      res_num_q    <= res_num_d;
      res_err_q    <= res_err_d;
    end
  end

  assign fill_done           = (state_q == READY);
  assign overflow            = overflow_q;
  assign dbg_state           = state_q;
  assign lk.lookup_ready     = (state_q == READY) && !(|lat_q);
  assign lk.result_valid     = lat_q[ITW_READ_LATENCY-1];
  assign lk.result_start_row = res_start_q;
  assign lk.result_num_rows  = res_num_q;
  assign lk.result_err       = res_err_q;

endmodule

// File: tb/tb_index_table_writer.sv
// Bench for index_table_writer: directed layers plus randomized layers, checked
// against a per-layer model of cumulative row totals.
module tb_index_table_writer;
  import index_table_pkg::*;

  localparam int unsigned ACT_LIMIT = 1 << ADDR_WIDTH_ACT;

  logic        clk = 1'b0;
  logic        arst_n_in;
  logic        start;
  logic [10:0] expected_entries;
  logic        delayed_CE;
  logic [10:0] delayed_masks_transferred;
  logic [31:0] activation_rows_total;
  logic        fill_done;
  logic        overflow;
  itw_state_t  dbg_state;

  index_table_writer_if lk();

  index_table_writer dut (
    .clk                       (clk),
    .arst_n_in                 (arst_n_in),
    .start                     (start),
    .expected_entries          (expected_entries),
    .delayed_CE                (delayed_CE),
    .delayed_masks_transferred (delayed_masks_transferred),
    .activation_rows_total     (activation_rows_total),
    .fill_done                 (fill_done),
    .overflow                  (overflow),
    .dbg_state                 (dbg_state),
    .lk                        (lk)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: row totals seen since the layer started.
  int unsigned m_prev = 0;
  int unsigned m_base = 0;
  int          m_expected = 0;
  int          m_count = 0;
  bit          m_ovf = 1'b0;
  logic [13:0] m_start_row [int];
  logic [13:0] m_num_rows  [int];

  function automatic void model_start(input int n);
    m_base     = m_prev;
    m_expected = n;
    m_count    = 0;
    m_ovf      = 1'b0;
    m_start_row.delete();
    m_num_rows.delete();
  endfunction

  function automatic void model_strobe(input int idx, input int unsigned total);
    int unsigned rows_before;
    int unsigned rows_in_group;
    if (idx % 2 == 1) begin
      if (m_count < m_expected) begin
        rows_before   = m_prev - m_base;
        rows_in_group = total - m_prev;
        if (rows_before >= ACT_LIMIT || rows_in_group >= ACT_LIMIT) m_ovf = 1'b1;
        m_start_row[idx / 2] = rows_before[13:0];
        m_num_rows[idx / 2]  = rows_in_group[13:0];
        m_count++;
      end
      m_prev = total;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_strobe(input int idx, input int unsigned total);
    model_strobe(idx, total);
    delayed_CE                = 1'b1;
    delayed_masks_transferred = idx[10:0];
    activation_rows_total     = total;
    tick();
    delayed_CE = 1'b0;
  endtask

  task automatic pulse_start(input int n, input bit with_ce, input int idx, input int unsigned total);
    model_start(n);
    if (with_ce && (idx % 2 == 1)) m_prev = total;
    start                     = 1'b1;
    expected_entries          = n[10:0];
    delayed_CE                = with_ce;
    delayed_masks_transferred = idx[10:0];
    activation_rows_total     = total;
    tick();
    start      = 1'b0;
    delayed_CE = 1'b0;
  endtask

  task automatic do_lookup(input int idx);
    logic        exp_err;
    logic [13:0] exp_start;
    logic [13:0] exp_num;
    int          waited = 0;
    while (lk.lookup_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (lk.lookup_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL lookup_ready_timeout idx=%0d got=%b exp=1", idx, lk.lookup_ready);
      return;
    end
    exp_err   = (idx >= m_expected);
    exp_start = exp_err ? 14'd0 : m_start_row[idx];
    exp_num   = exp_err ? 14'd0 : m_num_rows[idx];
    lk.lookup_valid = 1'b1;
    lk.lookup_index = idx[9:0];
    tick();
    lk.lookup_valid = 1'b0;
    n_checks++;
    if (lk.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL result_valid_early idx=%0d got=%b exp=0", idx, lk.result_valid);
    end
    n_checks++;
    if (lk.lookup_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_busy1 idx=%0d got=%b exp=0", idx, lk.lookup_ready);
    end
    tick();
    n_checks++;
    if (lk.result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL result_valid_lat2 idx=%0d got=%b exp=1", idx, lk.result_valid);
    end
    n_checks++;
    if ({lk.result_err, lk.result_start_row, lk.result_num_rows} !== {exp_err, exp_start, exp_num}) begin
      n_fail++;
      $display("FAIL result_data idx=%0d got err=%b start=%0d num=%0d exp err=%b start=%0d num=%0d",
               idx, lk.result_err, lk.result_start_row, lk.result_num_rows, exp_err, exp_start, exp_num);
    end
    n_checks++;
    if (lk.lookup_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_busy2 idx=%0d got=%b exp=0", idx, lk.lookup_ready);
    end
    tick();
    n_checks++;
    if (lk.result_valid !== 1'b0 || lk.lookup_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL after_response idx=%0d got valid=%b ready=%b exp valid=0 ready=1", idx, lk.result_valid, lk.lookup_ready);
    end
    n_checks++;
    if ({lk.result_start_row, lk.result_num_rows} !== {exp_start, exp_num}) begin
      n_fail++;
      $display("FAIL result_hold idx=%0d got start=%0d num=%0d exp start=%0d num=%0d",
               idx, lk.result_start_row, lk.result_num_rows, exp_start, exp_num);
    end
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0;
    start = 1'b0;
    expected_entries = '0;
    delayed_CE = 1'b0;
    delayed_masks_transferred = '0;
    activation_rows_total = '0;
    lk.lookup_valid = 1'b0;
    lk.lookup_index = '0;
    repeat (3) tick();
    n_checks++;
    if ({fill_done, overflow, lk.lookup_ready, lk.result_valid, lk.result_err} !== 5'b0 ||
        lk.result_start_row !== 14'd0 || lk.result_num_rows !== 14'd0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs got fd=%b ovf=%b rdy=%b rv=%b err=%b st=%0d num=%0d state=%0d exp all 0",
               fill_done, overflow, lk.lookup_ready, lk.result_valid, lk.result_err,
               lk.result_start_row, lk.result_num_rows, dbg_state);
    end
    arst_n_in = 1'b1;
    tick();
    n_checks++;
    if (dbg_state !== IDLE || lk.lookup_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset got state=%0d ready=%b exp state=0 ready=0", dbg_state, lk.lookup_ready);
    end
  endtask

  task automatic test_fill_basic();
    int unsigned totals [3] = '{10, 25, 25};
    pulse_start(3, 1'b0, 0, 0);
    n_checks++;
    if (dbg_state !== FILL) begin
      n_fail++;
      $display("FAIL enter_fill got=%0d exp=%0d", dbg_state, FILL);
    end
    for (int k = 0; k < 3; k++) begin
      drive_strobe(2 * k + 1, totals[k]);
      n_checks++;
      if (fill_done !== (m_count == m_expected)) begin
        n_fail++;
        $display("FAIL fill_done_basic k=%0d got=%b exp=%b", k, fill_done, m_count == m_expected);
      end
    end
    for (int i = 0; i < 3; i++) do_lookup(i);
  endtask

  task automatic test_second_layer();
    pulse_start(2, 1'b0, 0, 0);
    drive_strobe(1, 40);
    drive_strobe(3, 48);
    n_checks++;
    if (fill_done !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_done_layer2 got=%b exp=1", fill_done);
    end
    do_lookup(0);
    do_lookup(1);
  endtask

  task automatic test_even_ignored();
    int          idxs [6] = '{0, 1, 2, 3, 4, 5};
    int unsigned offs [6] = '{951, 10, 7729, 25, 3, 25};
    int unsigned b;
    b = m_prev;
    pulse_start(3, 1'b0, 0, 0);
    foreach (idxs[i]) begin
      drive_strobe(idxs[i], b + offs[i]);
      n_checks++;
      if (fill_done !== (m_count == m_expected)) begin
        n_fail++;
        $display("FAIL fill_done_even i=%0d got=%b exp=%b", i, fill_done, m_count == m_expected);
      end
    end
    for (int i = 0; i < 3; i++) do_lookup(i);
  endtask

  task automatic test_out_of_range_and_fill_block();
    do_lookup(3);
    do_lookup(1023);
    pulse_start(2, 1'b0, 0, 0);
    lk.lookup_valid = 1'b1;
    lk.lookup_index = 10'd0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (lk.lookup_ready !== 1'b0 || lk.result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL lookup_in_fill c=%0d got ready=%b rv=%b exp 0 0", c, lk.lookup_ready, lk.result_valid);
      end
      tick();
    end
    lk.lookup_valid = 1'b0;
    drive_strobe(1, m_prev + 3);
    drive_strobe(3, m_prev + 4);
    do_lookup(0);
    do_lookup(1);
  endtask

  task automatic test_overflow();
    pulse_start(1, 1'b0, 0, 0);
    drive_strobe(1, m_prev + 20000);
    n_checks++;
    if (overflow !== 1'b1 || overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow_set got=%b exp=%b", overflow, m_ovf);
    end
    repeat (3) tick();
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky got=%b exp=1", overflow);
    end
    do_lookup(0);
    pulse_start(1, 1'b0, 0, 0);
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear got=%b exp=0", overflow);
    end
    drive_strobe(1, m_prev + 16383);
    n_checks++;
    if (overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow_edge got=%b exp=%b", overflow, m_ovf);
    end
    do_lookup(0);
  endtask

  task automatic test_start_mid_fill();
    pulse_start(3, 1'b0, 0, 0);
    drive_strobe(1, m_prev + 5);
    pulse_start(2, 1'b0, 0, 0);
    n_checks++;
    if (dbg_state !== FILL || fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_fill got state=%0d fd=%b exp state=%0d fd=0", dbg_state, fill_done, FILL);
    end
    drive_strobe(1, m_prev + 11);
    n_checks++;
    if (fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_count got fd=%b exp=0", fill_done);
    end
    drive_strobe(3, m_prev + 2);
    n_checks++;
    if (fill_done !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_done got fd=%b exp=1", fill_done);
    end
    do_lookup(0);
    do_lookup(1);
  endtask

  task automatic test_start_with_write();
    pulse_start(2, 1'b0, 0, 0);
    drive_strobe(1, m_prev + 3);
    pulse_start(1, 1'b1, 3, m_prev + 5);
    drive_strobe(1, m_prev + 7);
    n_checks++;
    if (fill_done !== 1'b1) begin
      n_fail++;
      $display("FAIL start_wins_done got fd=%b exp=1", fill_done);
    end
    do_lookup(0);
  endtask

  task automatic test_start_during_pending();
    lk.lookup_valid = 1'b1;
    lk.lookup_index = 10'd0;
    tick();
    lk.lookup_valid = 1'b0;
    pulse_start(0, 1'b0, 0, 0);
    n_checks++;
    if (lk.result_valid !== 1'b0 || dbg_state !== FILL) begin
      n_fail++;
      $display("FAIL pending_drop1 got rv=%b state=%0d exp rv=0 state=%0d", lk.result_valid, dbg_state, FILL);
    end
    tick();
    n_checks++;
    if (lk.result_valid !== 1'b0 || dbg_state !== READY || fill_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_drop2 got rv=%b state=%0d fd=%b exp rv=0 state=%0d fd=1",
               lk.result_valid, dbg_state, fill_done, READY);
    end
    tick();
    n_checks++;
    if (lk.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_drop3 got rv=%b exp=0", lk.result_valid);
    end
    do_lookup(0);
  endtask

  task automatic test_random();
    int n;
    int order [$];
    for (int layer = 0; layer < 5; layer++) begin
      n = $urandom_range(1, 8);
      pulse_start(n, 1'b0, 0, 0);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) == 0) drive_strobe(2 * k, $urandom);
        if ($urandom_range(0, 2) == 0) tick();
        drive_strobe(2 * k + 1, m_prev + $urandom_range(0, 400));
        n_checks++;
        if (fill_done !== (m_count == m_expected)) begin
          n_fail++;
          $display("FAIL fill_done_rand layer=%0d k=%0d got=%b exp=%b", layer, k, fill_done, m_count == m_expected);
        end
      end
      n_checks++;
      if (overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL overflow_rand layer=%0d got=%b exp=%b", layer, overflow, m_ovf);
      end
      order.delete();
      for (int k = 0; k < n; k++) order.push_back(k);
      order.shuffle();
      foreach (order[i]) do_lookup(order[i]);
      do_lookup(n + $urandom_range(0, 20));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_basic();
    test_second_layer();
    test_even_ignored();
    test_out_of_range_and_fill_block();
    test_overflow();
    test_start_mid_fill();
    test_start_with_write();
    test_start_during_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/index_table_writer.md
Name: index_table_writer

Overview:
- Downstream consumer of the index-table row-count stage.
- Each accepted update carries the cumulative activation-row total after one mask pair (two MEM_BW-bit mask words). The block converts it into a per-group entry {start_row, num_rows} and stores it in an on-chip table.
- When the table is full, the block serves lookups from the compressed-activation fetch controller through a valid/ready request and a fixed-latency response.

Parameters:
- ADDR_WIDTH_MASKS, 11, width of the mask-transfer index; table address = index >> 1.
- ADDR_WIDTH_ACT, 14, width of stored start_row and num_rows fields.
- TABLE_DEPTH, 2**(ADDR_WIDTH_MASKS-1), number of entries.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: clear table state, capture layer base, enter FILL.
- expected_entries  in  ADDR_WIDTH_MASKS  number of mask pairs in the layer; sampled on start.
- delayed_CE  in  1  upstream update strobe.
- delayed_masks_transferred  in  ADDR_WIDTH_MASKS  upstream mask-word index.
- activation_rows_total  in  32  upstream cumulative row total; never reset between layers.
- fill_done  out  1  high in READY.
- overflow  out  1  sticky error flag: a field exceeded ADDR_WIDTH_ACT bits.
- lookup_valid  in  1  lookup request.
- lookup_ready  out  1  block accepts a lookup request.
- lookup_index  in  ADDR_WIDTH_MASKS-1  group to look up.
- result_valid  out  1  response strobe.
- result_start_row  out  ADDR_WIDTH_ACT  first compressed row of the group.
- result_num_rows  out  ADDR_WIDTH_ACT  row count of the group.
- result_err  out  1  lookup_index >= expected_entries.

Behaviour:
- Reset (async, arst_n_in low):
  - State IDLE.
  - All outputs 0; prev_total, base, entry_cnt, expected reg = 0.
  - Table contents are don't-care.
- FSM states IDLE, FILL, READY:
  - IDLE -> FILL on start.
  - FILL -> READY on the cycle entry_cnt reaches expected reg after a write.
  - READY -> FILL on start.
  - start in any state, including mid-FILL: entry_cnt=0, expected reg <= expected_entries, base <= prev_total, overflow <= 0, state FILL.
  - start with expected_entries=0 goes to FILL then READY on the next cycle, with no writes.
- Accepted write condition: state FILL && delayed_CE && delayed_masks_transferred[0]==1. Even indices are ignored because they are half pairs.
- On an accepted write:
  - addr = delayed_masks_transferred >> 1.
  - entry = {prev_total - base, activation_rows_total - prev_total}.
  - Write entry to table[addr].
  - prev_total <= activation_rows_total.
  - entry_cnt++.
- prev_total also updates on odd-index delayed_CE strobes outside FILL, so the base stays consistent with the upstream accumulator.
- Arithmetic:
  - All differences are computed in 32 bits.
  - If either difference is >= 2**ADDR_WIDTH_ACT, set overflow, which holds until the next start or reset.
  - Stored fields are truncated.
- start and an accepted write in the same cycle: start wins, but prev_total still updates. The write's data is not stored and entry_cnt stays 0.
- Lookup handshake:
  - lookup_ready = (state==READY) && !pending.
  - Transfer occurs on lookup_valid && lookup_ready.
  - Synchronous table read; result_valid pulses exactly 2 cycles after the transfer: 1 cycle memory read, 1 output register.
  - pending covers that window, so one lookup is outstanding at a time and lookup_ready is low for 2 cycles after each transfer.
  - result fields hold their values until the next response.
- Out-of-range lookup (lookup_index >= expected reg): result_err=1 and fields=0, same latency.
- start while a lookup is pending: the pending response is dropped; result_valid does not pulse.
- Writes in FILL beyond TABLE_DEPTH cannot occur because addr width limits them. A write to an already-written address overwrites it and still increments entry_cnt.

Decomposition:
- Shared package index_table_pkg holds:
  - typedef index_entry_t {start_row, num_rows}, each ADDR_WIDTH_ACT bits.
  - enum itw_state_t {IDLE, FILL, READY}.
  - Constant ITW_READ_LATENCY = 2.
- Sub-module index_table_mem: 1W1R register-array memory, TABLE_DEPTH x index_entry_t, synchronous read, no reset on the array.

Test Plan:
- Reset, then start with expected_entries=3. Feed totals 10, 25, 25 on odd indices 1, 3, 5 with prev_total=0 -> fill_done high 1 cycle after the third write. Lookups 0, 1, 2 -> {0,10}, {10,15}, {25,0}, each result_valid 2 cycles after acceptance.
- Second layer: start, expected=2, upstream continues at 40 and 48 -> base=25; entries {0,15}, {15,8}.
- Even-index strobes interleaved with different totals -> ignored; table matches the first scenario.
- lookup_index=3 with expected=3 -> result_err=1, fields 0. lookup_valid asserted during FILL -> lookup_ready stays 0 and no transfer occurs.
- Total jump of 20000 with ADDR_WIDTH_ACT=14 -> overflow=1 sticky; cleared by the next start.
- start asserted mid-FILL after 1 write, and again during a pending lookup -> entry_cnt restarts at 0, FSM re-enters FILL, no stale result_valid pulse appears.
